// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, default geometry and width helpers for the convolution scheduler
package conv_pkg;

  localparam int CONV_INW  = 24;
  localparam int CONV_R    = 9;
  localparam int CONV_C    = 8;
  localparam int CONV_MAXK = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  function automatic int k_bits(input int maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int x_addr_bits(input int r, input int c);
    return $clog2(r * c);
  endfunction

  function automatic int row_bits(input int r);
    return $clog2(r);
  endfunction

  function automatic int col_bits(input int c);
    return $clog2(c);
  endfunction

  function automatic logic k_legal(input int k, input int maxk, input int r, input int c);
    return (k >= 1) && (k <= maxk) && (k <= r) && (k <= c);
  endfunction

endpackage

// File: rtl/conv_scheduler_raster_counter.sv
// rtl/conv_scheduler_raster_counter.sv - row/column raster counter for the X read side
module raster_counter
  import conv_pkg::*;
#(
  parameter int R = CONV_R,
  parameter int C = CONV_C,
  localparam int ROW_BITS = row_bits(R),
  localparam int COL_BITS = col_bits(C)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col,
  output logic                last
);

  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(R - 1);
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(C - 1);

  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (en) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + ROW_BITS'(1);
      end else begin
        r_col <= r_col + COL_BITS'(1);
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = (r_row == ROW_MAX) && (r_col == COL_MAX);

endmodule

// File: rtl/conv_scheduler.sv
// rtl/conv_scheduler.sv - streams X in raster order and hands complete KxK windows to the MAC stage
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int R    = CONV_R,
  parameter int C    = CONV_C,
  parameter int MAXK = CONV_MAXK,
  localparam int K_BITS      = k_bits(MAXK),
  localparam int X_ADDR_BITS = x_addr_bits(R, C),
  localparam int ROW_BITS    = row_bits(R),
  localparam int COL_BITS    = col_bits(C)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  output logic                   pixel_valid,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [ROW_BITS-1:0]    out_row,
  output logic [COL_BITS-1:0]    out_col,
  output logic                   out_last,
  output logic                   compute_finished,
  output logic                   k_err
);

  sched_state_t r_state, w_next;

  logic [K_BITS-1:0]      r_k_q;
  logic [X_ADDR_BITS-1:0] r_addr;
  logic                   r_p_valid;
  logic [ROW_BITS-1:0]    r_p_row;
  logic [COL_BITS-1:0]    r_p_col;
  logic                   r_win_valid;
  logic [ROW_BITS-1:0]    r_out_row;
  logic [COL_BITS-1:0]    r_out_col;
  logic                   r_out_last;
  logic                   r_cf;
  logic                   r_k_err;

  logic                   w_k_ok, w_advance, w_issue, w_transfer, w_clr;
  logic [ROW_BITS-1:0]    w_rd_row;
  logic [COL_BITS-1:0]    w_rd_col;
  logic                   w_rd_last;
  logic [15:0]            w_row_ext, w_col_ext, w_km1;
  logic                   w_full_patch, w_pix_last;

  assign w_k_ok     = k_legal(int'(K), MAXK, R, C);
  assign w_advance  = ~r_win_valid | win_ready;
  assign w_issue    = (r_state == STREAM) & w_advance;
  assign w_transfer = r_win_valid & win_ready;
  assign w_clr      = (r_state == IDLE);

  raster_counter #(.R(R), .C(C)) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_issue),
    .row   (w_rd_row),
    .col   (w_rd_col),
    .last  (w_rd_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // DONE spans two cycles so compute_finished is seen while still out of IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (inputs_loaded) w_next = w_k_ok ? STREAM : DONE;
      STREAM:  if (w_issue && w_rd_last) w_next = DRAIN;
      DRAIN:   if (w_transfer && r_out_last) w_next = DONE;
      DONE:    if (r_cf) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k_q   <= '0;
      r_cf    <= 1'b0;
      r_k_err <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_cf    <= (r_state == DONE) & ~r_cf;
      r_k_err <= (r_state == IDLE) & inputs_loaded & ~w_k_ok;
      if (r_state == IDLE && inputs_loaded) r_k_q <= K;
      if (w_clr)        r_addr <= '0;
      else if (w_issue) r_addr <= w_rd_last ? '0 : r_addr + X_ADDR_BITS'(1);
    end
  end

  assign w_row_ext    = 16'(r_p_row);
  assign w_col_ext    = 16'(r_p_col);
  assign w_km1        = 16'(r_k_q) - 16'd1;
  assign w_full_patch = (w_row_ext >= w_km1) && (w_col_ext >= w_km1);
  assign w_pix_last   = (w_row_ext == 16'(R - 1)) && (w_col_ext == 16'(C - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p_valid   <= 1'b0;
      r_p_row     <= '0;
      r_p_col     <= '0;
      r_win_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_advance) begin
      r_p_valid   <= w_issue;
      r_p_row     <= w_rd_row;
      r_p_col     <= w_rd_col;
      r_win_valid <= r_p_valid & w_full_patch;
      r_out_row   <= ROW_BITS'(w_row_ext - w_km1);
      r_out_col   <= COL_BITS'(w_col_ext - w_km1);
      r_out_last  <= r_p_valid & w_pix_last;
    end
  end

  assign X_read_addr      = r_addr;
  assign pixel_valid      = r_p_valid & w_advance;
  assign win_valid        = r_win_valid;
  assign out_row          = r_out_row;
  assign out_col          = r_out_col;
  assign out_last         = r_out_last;
  assign compute_finished = r_cf;
  assign k_err            = r_k_err;

endmodule

// File: tb/tb_conv_scheduler.sv
// tb/tb_conv_scheduler.sv - directed self-checking bench for conv_scheduler
module tb_conv_scheduler;

  localparam int R = 9;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inputs_loaded = 1'b0;
  logic [2:0] K = 3'd0;
  logic       win_ready = 1'b0;
  logic [6:0] X_read_addr;
  logic       pixel_valid, win_valid, out_last, compute_finished, k_err;
  logic [3:0] out_row;
  logic [2:0] out_col;

  int n_cmp = 0;
  int n_bad = 0;

  int rows[$], cols[$], lasts[$];
  int n_xfer, first_wv, cf_rel, cf_abs, kerr_cyc, kerr_cnt, wv_cnt, pv_cnt;
  int stab_err, pv_err, addr_at1, cf_after, pass_done, hit_rst;

  conv_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .inputs_loaded    (inputs_loaded),
    .K                (K),
    .X_read_addr      (X_read_addr),
    .pixel_valid      (pixel_valid),
    .win_valid        (win_valid),
    .win_ready        (win_ready),
    .out_row          (out_row),
    .out_col          (out_col),
    .out_last         (out_last),
    .compute_finished (compute_finished),
    .k_err            (k_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected patch order: raster over the (R-k+1) x (C-k+1) output grid.
  function automatic int order_errs(input int k);
    int w, n, e;
    w = C - k + 1;
    n = (R - k + 1) * w;
    e = 0;
    for (int i = 0; i < rows.size(); i++) begin
      if (rows[i] != i / w || cols[i] != i % w || lasts[i] != ((i == n - 1) ? 1 : 0)) e++;
    end
    return e;
  endfunction

  task automatic run_pass(input int k, input int mode, input int k_new_at, input int k_new,
                          input int il_drop_at, input int rst_at, input int budget);
    int c;
    bit stp, fin;
    logic [6:0] pa;
    logic [3:0] pr;
    logic [2:0] pcl;
    logic pl;
    rows.delete(); cols.delete(); lasts.delete();
    n_xfer = 0; first_wv = -1; cf_rel = -1; cf_abs = -1; kerr_cyc = -1; kerr_cnt = 0;
    wv_cnt = 0; pv_cnt = 0; stab_err = 0; pv_err = 0; addr_at1 = -1; cf_after = -1;
    pass_done = 0; hit_rst = 0;
    stp = 0; fin = 0; c = 0;
    pa = '0; pr = '0; pcl = '0; pl = 1'b0;
    @(posedge clk); #1;
    K = 3'(k);
    inputs_loaded = 1'b1;
    win_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    while (!fin && c < budget) begin
      @(negedge clk);
      if (stp && (X_read_addr !== pa || win_valid !== 1'b1 || out_row !== pr ||
                  out_col !== pcl || out_last !== pl)) stab_err++;
      if (win_valid === 1'b1 && win_ready === 1'b0 && pixel_valid !== 1'b0) pv_err++;
      if (pixel_valid === 1'b1) pv_cnt++;
      if (win_valid === 1'b1) begin
        wv_cnt++;
        if (first_wv < 0) first_wv = c - 1;
      end
      if (c == 1) addr_at1 = int'(X_read_addr);
      if (win_valid === 1'b1 && win_ready === 1'b1) begin
        rows.push_back(int'(out_row));
        cols.push_back(int'(out_col));
        lasts.push_back(int'(out_last));
        n_xfer++;
      end
      if (k_err === 1'b1) begin
        kerr_cnt++;
        kerr_cyc = c;
      end
      stp = (win_valid === 1'b1) && (win_ready === 1'b0);
      pa = X_read_addr; pr = out_row; pcl = out_col; pl = out_last;
      if (compute_finished === 1'b1) begin
        cf_abs = c;
        cf_rel = c - 1;
        fin = 1;
        pass_done = 1;
        @(posedge clk); #1;
        inputs_loaded = 1'b0;
        win_ready = 1'b1;
        @(negedge clk);
        cf_after = (compute_finished === 1'b0) ? 0 : 1;
      end else if (rst_at > 0 && n_xfer == rst_at) begin
        hit_rst = 1;
        fin = 1;
        pass_done = 1;
      end else begin
        @(posedge clk); #1;
        c++;
        if (c == il_drop_at) inputs_loaded = 1'b0;
        if (c == k_new_at) K = 3'(k_new);
        win_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    if (!fin) begin
      inputs_loaded = 1'b0;
      win_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    reset = 1'b0;
    inputs_loaded = 1'b1;
    K = 3'd3;
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {X_read_addr, pixel_valid, win_valid, out_row, out_col, out_last, compute_finished, k_err};
    n_cmp++;
    if (outs !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    inputs_loaded = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (win_valid !== 1'b0 || pixel_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_quiet: win_valid=%b pixel_valid=%b expected 0", win_valid, pixel_valid);
    end
  endtask

  task automatic test_k3_nominal();
    run_pass(3, 0, -1, 0, -1, 0, 400);
    n_cmp++; if (pass_done !== 1) begin n_bad++; $display("FAIL k3_done: got %0d expected 1", pass_done); end
    n_cmp++; if (n_xfer !== 42) begin n_bad++; $display("FAIL k3_count: got %0d expected 42", n_xfer); end
    n_cmp++; if (order_errs(3) !== 0) begin n_bad++; $display("FAIL k3_order: got %0d bad patches expected 0", order_errs(3)); end
    n_cmp++; if (first_wv !== 20) begin n_bad++; $display("FAIL k3_first_latency: got %0d expected 20", first_wv); end
    if (rows.size() == 42) begin
      n_cmp++;
      if (rows[41] !== 6 || cols[41] !== 5 || lasts[41] !== 1) begin
        n_bad++;
        $display("FAIL k3_last_patch: got (%0d,%0d,last=%0d) expected (6,5,last=1)", rows[41], cols[41], lasts[41]);
      end
    end
    n_cmp++; if (cf_rel !== 75) begin n_bad++; $display("FAIL k3_cf_timing: got %0d expected 75", cf_rel); end
    n_cmp++; if (cf_after !== 0) begin n_bad++; $display("FAIL k3_cf_width: got %0d expected 0", cf_after); end
    n_cmp++; if (addr_at1 !== 0) begin n_bad++; $display("FAIL k3_first_addr: got %0d expected 0", addr_at1); end
    n_cmp++; if (pv_cnt !== 72) begin n_bad++; $display("FAIL k3_pixel_count: got %0d expected 72", pv_cnt); end
    n_cmp++; if (kerr_cnt !== 0) begin n_bad++; $display("FAIL k3_no_kerr: got %0d expected 0", kerr_cnt); end
  endtask

  task automatic test_stall();
    run_pass(3, 1, 10, 2, -1, 0, 3000);
    n_cmp++; if (pass_done !== 1) begin n_bad++; $display("FAIL stall_done: got %0d expected 1", pass_done); end
    n_cmp++; if (n_xfer !== 42) begin n_bad++; $display("FAIL stall_count: got %0d expected 42", n_xfer); end
    n_cmp++; if (order_errs(3) !== 0) begin n_bad++; $display("FAIL stall_order: got %0d bad patches expected 0", order_errs(3)); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stab_err); end
    n_cmp++; if (pv_err !== 0) begin n_bad++; $display("FAIL stall_pixel_valid: got %0d cycles expected 0", pv_err); end
    n_cmp++; if (pv_cnt !== 72) begin n_bad++; $display("FAIL stall_pixel_count: got %0d expected 72", pv_cnt); end
  endtask

  task automatic test_k1();
    run_pass(1, 0, -1, 0, -1, 0, 400);
    n_cmp++; if (n_xfer !== 72) begin n_bad++; $display("FAIL k1_count: got %0d expected 72", n_xfer); end
    n_cmp++; if (order_errs(1) !== 0) begin n_bad++; $display("FAIL k1_order: got %0d bad patches expected 0", order_errs(1)); end
    n_cmp++; if (first_wv !== 2) begin n_bad++; $display("FAIL k1_first_latency: got %0d expected 2", first_wv); end
    n_cmp++; if (cf_rel !== 75) begin n_bad++; $display("FAIL k1_cf_timing: got %0d expected 75", cf_rel); end
  endtask

  task automatic test_k4();
    run_pass(4, 0, -1, 0, 5, 0, 400);
    n_cmp++; if (n_xfer !== 30) begin n_bad++; $display("FAIL k4_count: got %0d expected 30", n_xfer); end
    n_cmp++; if (order_errs(4) !== 0) begin n_bad++; $display("FAIL k4_order: got %0d bad patches expected 0", order_errs(4)); end
    n_cmp++; if (first_wv !== 29) begin n_bad++; $display("FAIL k4_first_latency: got %0d expected 29", first_wv); end
    n_cmp++; if (cf_rel !== 75) begin n_bad++; $display("FAIL k4_cf_timing: got %0d expected 75", cf_rel); end
  endtask

  task automatic test_kerr();
    int kv[2];
    kv[0] = 0;
    kv[1] = 5;
    for (int i = 0; i < 2; i++) begin
      run_pass(kv[i], 0, -1, 0, -1, 0, 50);
      n_cmp++; if (kerr_cyc !== 1) begin n_bad++; $display("FAIL kerr_cycle k=%0d: got %0d expected 1", kv[i], kerr_cyc); end
      n_cmp++; if (kerr_cnt !== 1) begin n_bad++; $display("FAIL kerr_pulses k=%0d: got %0d expected 1", kv[i], kerr_cnt); end
      n_cmp++; if (cf_abs !== 2) begin n_bad++; $display("FAIL kerr_cf_cycle k=%0d: got %0d expected 2", kv[i], cf_abs); end
      n_cmp++; if (wv_cnt !== 0 || pv_cnt !== 0) begin n_bad++; $display("FAIL kerr_no_patch k=%0d: got wv=%0d pv=%0d expected 0", kv[i], wv_cnt, pv_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] outs;
    run_pass(3, 0, -1, 0, -1, 10, 400);
    n_cmp++; if (hit_rst !== 1 || n_xfer !== 10) begin n_bad++; $display("FAIL rstmid_reach: got xfers=%0d expected 10", n_xfer); end
    @(posedge clk); #1;
    reset = 1'b0;
    inputs_loaded = 1'b0;
    #1;
    outs = {X_read_addr, pixel_valid, win_valid, out_row, out_col, out_last, compute_finished, k_err};
    n_cmp++;
    if (outs !== 19'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h expected 0", outs);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    run_pass(3, 0, -1, 0, -1, 0, 400);
    n_cmp++; if (n_xfer !== 42) begin n_bad++; $display("FAIL rstmid_count: got %0d expected 42", n_xfer); end
    n_cmp++; if (order_errs(3) !== 0) begin n_bad++; $display("FAIL rstmid_order: got %0d bad patches expected 0", order_errs(3)); end
    n_cmp++; if (cf_rel !== 75) begin n_bad++; $display("FAIL rstmid_cf_timing: got %0d expected 75", cf_rel); end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 2; p++) begin
      run_pass(3, 0, -1, 0, -1, 0, 400);
      n_cmp++; if (addr_at1 !== 0) begin n_bad++; $display("FAIL b2b_first_addr pass%0d: got %0d expected 0", p, addr_at1); end
      n_cmp++; if (n_xfer !== 42) begin n_bad++; $display("FAIL b2b_count pass%0d: got %0d expected 42", p, n_xfer); end
      n_cmp++; if (order_errs(3) !== 0) begin n_bad++; $display("FAIL b2b_order pass%0d: got %0d bad expected 0", p, order_errs(3)); end
      n_cmp++; if (first_wv !== 20) begin n_bad++; $display("FAIL b2b_first_latency pass%0d: got %0d expected 20", p, first_wv); end
      n_cmp++; if (cf_rel !== 75) begin n_bad++; $display("FAIL b2b_cf_timing pass%0d: got %0d expected 75", p, cf_rel); end
    end
  endtask

  initial begin
    test_reset();
    test_k3_nominal();
    test_stall();
    test_k1();
    test_k4();
    test_kerr();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
